// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave write receiver.
// Holds the FSM state enum, the byte length and the R/W bit encodings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } i2c_rx_state_e;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic I2C_RW_WRITE  = 1'b0;
  localparam logic I2C_RW_READ   = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for scl/sda plus a third flop for edge detection.
// Ports: clk, rst, scl, sda in; scl_rise, scl_fall, start_det, stop_det, sda_s out.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // bit0 = first sync flop, bit1 = synced value, bit2 = previous value
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl};
    sda_d = {sda_q[1:0], sda};
  end

  // Idle bus is high, so resetting to 1 avoids spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  logic scl_hi;
  assign scl_hi    = scl_q[1] & scl_q[2];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_hi & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_hi & ~sda_q[2] & sda_q[1];
  assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave: address match, ACK/NACK, byte strobe to consumer.
// Ports: scl/slavesda in, sda_pull/ack/data_out/data_valid/addr_match/busy out, rx_ready in.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter int                   DATAWIDTH  = 8,
  parameter int                   ADDRWIDTH  = 7,
  parameter logic [ADDRWIDTH-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  input  logic                 slavesda,
  output logic                 sda_pull,
  output logic                 ack,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 rx_ready,
  output logic                 addr_match,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (slavesda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_rx_state_e        state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATAWIDTH-2:0] shift_q, shift_d;
  logic                 pull_q, pull_d;
  logic                 ack_q, ack_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 match_q, match_d;
  logic                 busy_q, busy_d;
  // phase: 0 = waiting for the fall that starts the ACK slot,
  //        1 = waiting for the fall that ends it
  logic                 phase_q, phase_d;
  logic                 nack_q, nack_d;

  logic [DATAWIDTH-1:0] rx_byte;
  logic                 addr_ok;

  assign rx_byte = {shift_q, sda_s};
  assign addr_ok = (rx_byte[DATAWIDTH-1 -: ADDRWIDTH] == SLAVE_ADDR)
                && (rx_byte[0] != I2C_RW_READ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pull_d  = pull_q;
    ack_d   = 1'b0;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    match_d = match_q;
    busy_d  = busy_q;
    phase_d = phase_q;
    nack_d  = nack_q;

    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      pull_d  = 1'b0;
      match_d = 1'b0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      pull_d  = 1'b0;
      match_d = 1'b0;
      busy_d  = 1'b1;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte[DATAWIDTH-2:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == LAST_BIT) begin
              cnt_d   = '0;
              nack_d  = 1'b0;
              phase_d = 1'b0;
              state_d = addr_ok ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte[DATAWIDTH-2:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == LAST_BIT) begin
              cnt_d   = '0;
              phase_d = 1'b0;
              state_d = DATA_ACK;
              nack_d  = ~rx_ready;
              if (rx_ready) begin
                dout_d = rx_byte;
                dv_d   = 1'b1;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              if (!nack_q) begin
                pull_d = 1'b1;
                ack_d  = 1'b1;
              end
            end else begin
              phase_d = 1'b0;
              pull_d  = 1'b0;
              if (state_q == ADDR_ACK) begin
                match_d = 1'b1;
                state_d = DATA;
              end else begin
                state_d = nack_q ? WAIT_STOP : DATA;
              end
            end
          end
        end
        WAIT_STOP: pull_d = 1'b0;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pull_q  <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pull_q  <= pull_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
      nack_q  <= nack_d;
    end
  end

  assign sda_pull   = pull_q;
  assign ack        = ack_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign addr_match = match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed bench for i2c_slave_receiver: bit-banged master, byte scoreboard.
// Expected bytes are queued before sending and popped on each data_valid.
module tb_i2c_slave_receiver;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       slavesda;
  logic       sda_pull, ack, data_valid, rx_ready, addr_match, busy;
  logic [7:0] data_out;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] exp_q[$];

  // Open-drain bus: master or slave can pull low.
  assign slavesda = sda_m & ~sda_pull;

  always #5 clk = ~clk;

  i2c_slave_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .slavesda   (slavesda),
    .sda_pull   (sda_pull),
    .ack        (ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rx_ready   (rx_ready),
    .addr_match (addr_match),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ack) ack_cnt++;
    if (!rst && data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic qw();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl = 1'b1; qw();
    sda_m = 1'b1; qw();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; qw();
      scl = 1'b1; qw(); qw();
      scl = 1'b0; qw();
    end
  endtask

  task automatic ack_slot(output logic acked);
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    acked = ~slavesda;
    qw();
    scl = 1'b0; qw();
  endtask

  logic a;
  int   acks0, dvs0;

  initial begin
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_pull", 32'(sda_pull), 0);
    check("rst_dv", 32'(data_valid), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_match", 32'(addr_match), 0);
    rst = 1'b0;
    qw();

    // single write 0x50/W, 0xA5
    i2c_start();
    check("t1_busy", 32'(busy), 1);
    send_bits(8'hA0, 8); ack_slot(a);
    check("t1_addr_ack", 32'(a), 1);
    check("t1_match", 32'(addr_match), 1);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8); ack_slot(a);
    check("t1_data_ack", 32'(a), 1);
    i2c_stop();
    check("t1_busy_off", 32'(busy), 0);
    check("t1_match_off", 32'(addr_match), 0);
    check("t1_dv", 32'(dv_cnt), 1);
    check("t1_acks", 32'(ack_cnt), 2);
    check("t1_dout", 32'(data_out), 32'hA5);

    // wrong address 0x51/W
    acks0 = ack_cnt; dvs0 = dv_cnt;
    i2c_start();
    send_bits(8'hA2, 8); ack_slot(a);
    check("t2_addr_nack", 32'(a), 0);
    check("t2_match", 32'(addr_match), 0);
    send_bits(8'h12, 8); ack_slot(a);
    check("t2_data_nack", 32'(a), 0);
    i2c_stop();
    check("t2_acks", 32'(ack_cnt - acks0), 0);
    check("t2_dv", 32'(dv_cnt - dvs0), 0);

    // read request 0x50/R
    i2c_start();
    send_bits(8'hA1, 8); ack_slot(a);
    check("t3_nack", 32'(a), 0);
    check("t3_state", 32'(dut.state_q), 32'(WAIT_STOP));
    i2c_stop();
    check("t3_dv", 32'(dv_cnt - dvs0), 0);
    check("t3_idle", 32'(dut.state_q), 32'(IDLE));

    // burst of three bytes
    acks0 = ack_cnt; dvs0 = dv_cnt;
    i2c_start();
    send_bits(8'hA0, 8); ack_slot(a);
    exp_q.push_back(8'h11); send_bits(8'h11, 8); ack_slot(a);
    exp_q.push_back(8'h22); send_bits(8'h22, 8); ack_slot(a);
    exp_q.push_back(8'h33); send_bits(8'h33, 8); ack_slot(a);
    check("t4_last_ack", 32'(a), 1);
    i2c_stop();
    check("t4_acks", 32'(ack_cnt - acks0), 4);
    check("t4_dv", 32'(dv_cnt - dvs0), 3);

    // repeated START after a partial data byte
    dvs0 = dv_cnt;
    i2c_start();
    send_bits(8'hA0, 8); ack_slot(a);
    send_bits(8'hF0, 4);
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl = 1'b0; qw();
    check("t5_match_clr", 32'(addr_match), 0);
    check("t5_state", 32'(dut.state_q), 32'(ADDR));
    send_bits(8'hA0, 8); ack_slot(a);
    check("t5_addr_ack", 32'(a), 1);
    exp_q.push_back(8'h7E);
    send_bits(8'h7E, 8); ack_slot(a);
    i2c_stop();
    check("t5_dv", 32'(dv_cnt - dvs0), 1);

    // consumer not ready
    acks0 = ack_cnt; dvs0 = dv_cnt;
    i2c_start();
    send_bits(8'hA0, 8); ack_slot(a);
    rx_ready = 1'b0;
    send_bits(8'h3C, 8); ack_slot(a);
    check("t6_nack", 32'(a), 0);
    check("t6_state", 32'(dut.state_q), 32'(WAIT_STOP));
    send_bits(8'h55, 8); ack_slot(a);
    check("t6_ignored", 32'(a), 0);
    i2c_stop();
    rx_ready = 1'b1;
    check("t6_dv", 32'(dv_cnt - dvs0), 0);
    check("t6_acks", 32'(ack_cnt - acks0), 1);
    check("t6_dout_kept", 32'(data_out), 32'h7E);

    // async reset while ACKing the address
    i2c_start();
    send_bits(8'hA0, 8);
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    check("t7_pull_before", 32'(sda_pull), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7_pull_rst", 32'(sda_pull), 0);
    check("t7_busy_rst", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    qw();

    // recovery transfer
    dvs0 = dv_cnt;
    i2c_start();
    send_bits(8'hA0, 8); ack_slot(a);
    check("t8_addr_ack", 32'(a), 1);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8); ack_slot(a);
    i2c_stop();
    check("t8_dv", 32'(dv_cnt - dvs0), 1);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
